// File: rtl/mem_arb_pkg.sv
// Shared definitions for the multi-core data RAM arbiter:
// request codes, FSM states and the per-transaction request view.
package mem_arb_pkg;
    localparam int NUM_CORES_DEF = 4;
    localparam int DATA_W        = 16;

    typedef enum logic [1:0] {
        MC_IDLE  = 2'b00,
        MC_READ  = 2'b01,
        MC_WRITE = 2'b10,
        MC_RSVD  = 2'b11
    } mc_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic              is_write;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    // The reserved code counts as no request.
    function automatic logic mc_valid(input logic [1:0] mc);
        return (mc == MC_READ) || (mc == MC_WRITE);
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible requester after rr_ptr,
// with one optional index masked out.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    input  logic          mask_vld,
    input  logic [IW-1:0] mask_idx,
    output logic [IW-1:0] grant,
    output logic          grant_vld
);
    logic [N-1:0]  eligible;
    logic [IW-1:0] sel;
    int            pos;

    always_comb begin
        eligible = req;
        if (mask_vld) eligible[mask_idx] = 1'b0;
        grant     = '0;
        grant_vld = 1'b0;
        pos       = 0;
        sel       = '0;
        for (int i = 1; i <= N; i++) begin
            pos = int'(rr_ptr) + i;
            if (pos >= N) pos = pos - N;
            sel = IW'(pos);
            if (!grant_vld && eligible[sel]) begin
                grant     = sel;
                grant_vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous data RAM between NUM_CORES cores, serving one
// latched request at a time in round-robin order.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int NUM_CORES = NUM_CORES_DEF,
    localparam int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic [2*NUM_CORES-1:0]      core_memcontrol,
    input  logic [DATA_W*NUM_CORES-1:0] core_addr,
    input  logic [DATA_W*NUM_CORES-1:0] core_wdata,
    output logic [DATA_W-1:0]           core_rdata,
    output logic [NUM_CORES-1:0]        core_ready,
    output logic [DATA_W-1:0]           ram_addr,
    output logic [DATA_W-1:0]           ram_wdata,
    output logic                        ram_we,
    output logic                        ram_re,
    input  logic [DATA_W-1:0]           ram_rdata
);
    logic [NUM_CORES-1:0][1:0]        mc_arr;
    logic [NUM_CORES-1:0][DATA_W-1:0] addr_arr, wdata_arr;
    logic [NUM_CORES-1:0]             req_vld;

    state_e            state;
    logic [IDX_W-1:0]  rr_ptr, grant_q, mask_idx, arb_idx;
    logic              mask_vld, arb_vld, wr_q;
    logic [DATA_W-1:0] rdata_q;
    req_t              sel_req;

    assign mc_arr     = core_memcontrol;
    assign addr_arr   = core_addr;
    assign wdata_arr  = core_wdata;
    assign core_rdata = rdata_q;

    for (genvar k = 0; k < NUM_CORES; k++) begin : g_lane
        assign req_vld[k] = mc_valid(mc_arr[k]);
    end

    rr_arbiter #(.N(NUM_CORES)) u_rr (
        .req       (req_vld),
        .rr_ptr    (rr_ptr),
        .mask_vld  (mask_vld),
        .mask_idx  (mask_idx),
        .grant     (arb_idx),
        .grant_vld (arb_vld)
    );

    always_comb begin
        sel_req.is_write = (mc_arr[arb_idx] == MC_WRITE);
        sel_req.addr     = addr_arr[arb_idx];
        sel_req.wdata    = wdata_arr[arb_idx];
    end

    // RAM strobes are registered at grant so they are high exactly during ISSUE;
    // the RAM output registers double as the latched address/data.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= ST_IDLE;
            rr_ptr     <= IDX_W'(NUM_CORES - 1);
            grant_q    <= '0;
            wr_q       <= 1'b0;
            mask_vld   <= 1'b0;
            mask_idx   <= '0;
            rdata_q    <= '0;
            core_ready <= '0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_we     <= 1'b0;
            ram_re     <= 1'b0;
        end else begin
            core_ready <= '0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_we     <= 1'b0;
            ram_re     <= 1'b0;
            mask_vld   <= 1'b0;
            case (state)
                ST_IDLE: if (arb_vld) begin
                    grant_q   <= arb_idx;
                    rr_ptr    <= arb_idx;
                    wr_q      <= sel_req.is_write;
                    ram_addr  <= sel_req.addr;
                    ram_wdata <= sel_req.wdata;
                    ram_we    <= sel_req.is_write;
                    ram_re    <= !sel_req.is_write;
                    state     <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (wr_q) begin
                        core_ready[grant_q] <= 1'b1;
                        state               <= ST_RESP;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    rdata_q             <= ram_rdata;
                    core_ready[grant_q] <= 1'b1;
                    state               <= ST_RESP;
                end
                ST_RESP: begin
                    // Hide the just-served core for one IDLE cycle so a late drop isn't re-served.
                    mask_vld <= 1'b1;
                    mask_idx <= grant_q;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous RAM model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int NC = 4;

    logic                 Clock = 1'b0;
    logic                 Reset;
    logic [NC-1:0][1:0]   mc_arr;
    logic [NC-1:0][15:0]  addr_arr, wdata_arr;
    logic [15:0]          core_rdata, ram_addr, ram_wdata, ram_rdata;
    logic [NC-1:0]        core_ready;
    logic                 ram_we, ram_re;
    logic [15:0]          mem [256];

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.NUM_CORES(NC)) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .core_memcontrol (mc_arr),
        .core_addr       (addr_arr),
        .core_wdata      (wdata_arr),
        .core_rdata      (core_rdata),
        .core_ready      (core_ready),
        .ram_addr        (ram_addr),
        .ram_wdata       (ram_wdata),
        .ram_we          (ram_we),
        .ram_re          (ram_re),
        .ram_rdata       (ram_rdata)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr[7:0]];
    end

    task automatic set_req(input int c, input logic [1:0] mc, input logic [15:0] a, input logic [15:0] d);
        mc_arr[c]    = mc;
        addr_arr[c]  = a;
        wdata_arr[c] = d;
    endtask

    task automatic apply_reset();
        Reset     = 1'b1;
        mc_arr    = '0;
        addr_arr  = '0;
        wdata_arr = '0;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset     = 1'b1;
        mc_arr    = '0;
        addr_arr  = '0;
        wdata_arr = '0;
        @(negedge Clock);
        @(negedge Clock);
        checks++;
        if (core_ready !== 4'b0 || ram_we !== 1'b0 || ram_re !== 1'b0 || ram_addr !== 16'h0 ||
            ram_wdata !== 16'h0 || core_rdata !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs: ready=%b we=%b re=%b addr=%h wdata=%h rdata=%h, all required 0",
                     core_ready, ram_we, ram_re, ram_addr, ram_wdata, core_rdata);
        end
        checks++;
        if (dut.state !== ST_IDLE || dut.rr_ptr !== 2'd3) begin
            failures++;
            $display("FAIL reset_state: state=%0d rr_ptr=%0d, required IDLE rr_ptr=3", dut.state, dut.rr_ptr);
        end
        Reset = 1'b0;
    endtask

    task automatic test_write_read();
        @(negedge Clock);
        set_req(0, MC_WRITE, 16'h0010, 16'h00A5);
        @(negedge Clock);
        checks++;
        if (ram_we !== 1'b1 || ram_re !== 1'b0 || ram_addr !== 16'h0010 || ram_wdata !== 16'h00A5 || core_ready !== 4'b0) begin
            failures++;
            $display("FAIL wr_issue: we=%b re=%b addr=%h wdata=%h ready=%b, required we=1 re=0 addr=0010 wdata=00a5 ready=0000",
                     ram_we, ram_re, ram_addr, ram_wdata, core_ready);
        end
        @(negedge Clock);
        checks++;
        if (core_ready !== 4'b0001) begin
            failures++;
            $display("FAIL wr_ready: ready=%b, required 0001 after 2 edges", core_ready);
        end
        checks++;
        if (ram_we !== 1'b0 || ram_re !== 1'b0 || ram_addr !== 16'h0 || ram_wdata !== 16'h0) begin
            failures++;
            $display("FAIL wr_resp_ram_idle: we=%b re=%b addr=%h wdata=%h, required all 0", ram_we, ram_re, ram_addr, ram_wdata);
        end
        set_req(0, MC_IDLE, 16'h0, 16'h0);
        @(negedge Clock);
        checks++;
        if (core_ready !== 4'b0) begin
            failures++;
            $display("FAIL wr_single_pulse: ready=%b, required 0000", core_ready);
        end
        @(negedge Clock);
        set_req(0, MC_READ, 16'h0010, 16'h0);
        @(negedge Clock);
        checks++;
        if (ram_re !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 16'h0010 || ram_wdata !== 16'h0) begin
            failures++;
            $display("FAIL rd_issue: we=%b re=%b addr=%h wdata=%h, required we=0 re=1 addr=0010 wdata=0000",
                     ram_we, ram_re, ram_addr, ram_wdata);
        end
        @(negedge Clock);
        checks++;
        if (core_ready !== 4'b0 || ram_re !== 1'b0) begin
            failures++;
            $display("FAIL rd_wait: ready=%b re=%b, required 0000 and 0", core_ready, ram_re);
        end
        @(negedge Clock);
        checks++;
        if (core_ready !== 4'b0001 || core_rdata !== 16'h00A5) begin
            failures++;
            $display("FAIL rd_ready: ready=%b rdata=%h, required 0001 and 00a5 after 3 edges", core_ready, core_rdata);
        end
        set_req(0, MC_IDLE, 16'h0, 16'h0);
        @(negedge Clock);
        checks++;
        if (core_ready !== 4'b0 || core_rdata !== 16'h00A5) begin
            failures++;
            $display("FAIL rd_hold: ready=%b rdata=%h, required 0000 and 00a5", core_ready, core_rdata);
        end
    endtask

    task automatic test_all_contention();
        int cnt[NC];
        int seen    = 0;
        int issue_k = 0;
        for (int c = 0; c < NC; c++) cnt[c] = 0;
        apply_reset();
        for (int c = 0; c < NC; c++) set_req(c, MC_WRITE, 16'h0100 + 16'(c), 16'h1000 + 16'(c));
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge Clock);
            if (ram_we) begin
                checks++;
                if (ram_addr !== 16'h0100 + 16'(issue_k) || ram_wdata !== 16'h1000 + 16'(issue_k)) begin
                    failures++;
                    $display("FAIL contention_issue%0d: addr=%h wdata=%h, required %h %h",
                             issue_k, ram_addr, ram_wdata, 16'h0100 + 16'(issue_k), 16'h1000 + 16'(issue_k));
                end
                issue_k++;
            end
            if (core_ready != 4'b0) begin
                checks++;
                if (core_ready !== (4'b0001 << seen)) begin
                    failures++;
                    $display("FAIL contention_order%0d: ready=%b, required %b", seen, core_ready, 4'b0001 << seen);
                end
                for (int c = 0; c < NC; c++)
                    if (core_ready[c]) begin
                        cnt[c]++;
                        set_req(c, MC_IDLE, 16'h0, 16'h0);
                    end
                seen++;
            end
        end
        checks++;
        if (seen != NC) begin
            failures++;
            $display("FAIL contention_timeout: ready pulses=%0d, required 4 within 40 cycles", seen);
        end
        for (int c = 0; c < NC; c++) begin
            checks++;
            if (cnt[c] != 1) begin
                failures++;
                $display("FAIL contention_count_core%0d: pulses=%0d, required 1", c, cnt[c]);
            end
        end
    endtask

    task automatic test_held_request();
        int c2 = 0, c3 = 0, c1 = 0;
        int first = -1, t2 = -1, t1 = -1;
        @(negedge Clock);
        set_req(2, MC_READ, 16'h0010, 16'h0);
        set_req(3, MC_WRITE, 16'h0020, 16'h5A5A);
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge Clock);
            if (t2 >= 0 && cyc == t2 + 2) set_req(2, MC_IDLE, 16'h0, 16'h0);
            if (core_ready[2]) begin
                c2++;
                if (first < 0) first = 2;
                if (t2 < 0) begin
                    t2 = cyc;
                    checks++;
                    if (core_rdata !== 16'h00A5) begin
                        failures++;
                        $display("FAIL held_core2_rdata: rdata=%h, required 00a5", core_rdata);
                    end
                end
            end
            if (core_ready[3]) begin
                c3++;
                if (first < 0) first = 3;
                set_req(3, MC_IDLE, 16'h0, 16'h0);
            end
        end
        checks++;
        if (first != 2 || c2 != 1 || c3 != 1) begin
            failures++;
            $display("FAIL held_pair: first=%0d core2 pulses=%0d core3 pulses=%0d, required 2 1 1", first, c2, c3);
        end
        // Lone core holding its read through the following IDLE cycle.
        @(negedge Clock);
        set_req(1, MC_READ, 16'h0020, 16'h0);
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge Clock);
            if (t1 >= 0 && cyc == t1 + 2) set_req(1, MC_IDLE, 16'h0, 16'h0);
            if (core_ready[1]) begin
                c1++;
                if (t1 < 0) t1 = cyc;
            end
        end
        checks++;
        if (c1 != 1 || core_rdata !== 16'h5A5A) begin
            failures++;
            $display("FAIL held_alone: core1 pulses=%0d rdata=%h, required 1 and 5a5a", c1, core_rdata);
        end
    endtask

    task automatic test_reserved();
        @(negedge Clock);
        set_req(1, MC_RSVD, 16'h0033, 16'h7777);
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge Clock);
            checks++;
            if (ram_we !== 1'b0 || ram_re !== 1'b0 || core_ready !== 4'b0 || dut.state !== ST_IDLE) begin
                failures++;
                $display("FAIL reserved_cyc%0d: we=%b re=%b ready=%b state=%0d, required 0 0 0000 IDLE",
                         cyc, ram_we, ram_re, core_ready, dut.state);
            end
        end
        set_req(1, MC_IDLE, 16'h0, 16'h0);
    endtask

    task automatic test_reset_in_wait();
        int got = 0;
        @(negedge Clock);
        set_req(1, MC_READ, 16'h0020, 16'h0);
        @(negedge Clock);
        @(negedge Clock);
        checks++;
        if (dut.state !== ST_WAIT) begin
            failures++;
            $display("FAIL rstwait_reach: state=%0d, required WAIT", dut.state);
        end
        Reset = 1'b1;
        #1;
        checks++;
        if (dut.state !== ST_IDLE || dut.rr_ptr !== 2'd3 || core_rdata !== 16'h0 || core_ready !== 4'b0 ||
            ram_we !== 1'b0 || ram_re !== 1'b0 || ram_addr !== 16'h0 || ram_wdata !== 16'h0) begin
            failures++;
            $display("FAIL rstwait_abort: state=%0d rr=%0d rdata=%h ready=%b we=%b re=%b addr=%h wdata=%h, required IDLE 3 and zeros",
                     dut.state, dut.rr_ptr, core_rdata, core_ready, ram_we, ram_re, ram_addr, ram_wdata);
        end
        @(negedge Clock);
        checks++;
        if (core_ready !== 4'b0) begin
            failures++;
            $display("FAIL rstwait_no_pulse: ready=%b, required 0000", core_ready);
        end
        Reset = 1'b0;
        for (int cyc = 0; cyc < 10 && got == 0; cyc++) begin
            @(negedge Clock);
            if (core_ready != 4'b0) begin
                got = 1;
                checks++;
                if (core_ready !== 4'b0010 || core_rdata !== 16'h5A5A) begin
                    failures++;
                    $display("FAIL rstwait_retry: ready=%b rdata=%h, required 0010 and 5a5a", core_ready, core_rdata);
                end
            end
        end
        checks++;
        if (got == 0) begin
            failures++;
            $display("FAIL rstwait_timeout: no ready within 10 cycles after release, required core1 completion");
        end
        set_req(1, MC_IDLE, 16'h0, 16'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        ram_rdata = 16'h0;
        test_reset();
        test_write_read();
        test_all_contention();
        test_held_request();
        test_reserved();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_CORES, default 4, giving the number of cores sharing one data RAM.
REQ-002 The block SHALL have port Clock, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit, asynchronous and active-high.
REQ-004 The block SHALL have port core_memcontrol, input, 2*NUM_CORES bits, giving the per-core request code; core k uses bits [2k+1:2k].
REQ-005 The block SHALL have port core_addr, input, 16*NUM_CORES bits, giving the per-core address (the core AR output).
REQ-006 The block SHALL have port core_wdata, input, 16*NUM_CORES bits, giving the per-core write data (the core MDDR_out).
REQ-007 The block SHALL have port core_rdata, output, 16 bits, giving read data broadcast to all cores (feeds the core MDDR_in).
REQ-008 The block SHALL have port core_ready, output, NUM_CORES bits, a one-hot completion pulse per core.
REQ-009 The block SHALL have ports ram_addr (output, 16 bits) and ram_wdata (output, 16 bits) to the shared RAM.
REQ-010 The block SHALL have ports ram_we (output, 1 bit) and ram_re (output, 1 bit) to the shared RAM.
REQ-011 The block SHALL have port ram_rdata, input, 16 bits; read data is valid exactly one cycle after ram_re.

Function
REQ-012 memcontrol encoding SHALL be:
- 00: idle
- 01: read
- 10: write
- 11: reserved, treated as idle.
REQ-013 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-014 In IDLE, with at least one valid request, the FSM SHALL:
- grant the requesting core first in round-robin order, starting at rr_ptr+1 modulo NUM_CORES;
- latch that core's index, op, addr and wdata;
- set rr_ptr to the granted index;
- move to ISSUE.
REQ-015 In ISSUE, the block SHALL drive ram_addr and ram_wdata from the latches for one cycle, with ram_we=1 for a write or ram_re=1 for a read; next state SHALL be RESP for a write and WAIT for a read.
REQ-016 In WAIT, the block SHALL capture ram_rdata into rdata_q at the clock edge, then go to RESP.
REQ-017 In RESP, core_ready[grant] SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-018 core_rdata SHALL equal rdata_q at all times; it changes only when a read completes and holds through writes.
REQ-019 Latency, counted from the edge that samples the request to the first cycle of ready high:
- write: 2 edges;
- read: 3 edges.
REQ-020 Latched request fields SHALL be used for the whole transaction; a core dropping or changing its request after the grant does not affect it.
REQ-021 The core served in RESP SHALL be masked from arbitration in the IDLE cycle immediately following, so a request still held one cycle late is not serviced twice.
REQ-022 Simultaneous requests from all cores SHALL each be served exactly once within NUM_CORES transactions, with no starvation.
REQ-023 Requests arriving while the FSM is not in IDLE SHALL wait; no queueing beyond the held request lines.
REQ-024 ram_we and ram_re SHALL never both be 1, and both SHALL be 0 outside ISSUE.
REQ-025 ram_addr and ram_wdata SHALL be 0 outside ISSUE.
REQ-026 rr_ptr SHALL wrap from NUM_CORES-1 to 0.

Reset
REQ-027 While Reset=1, the block SHALL hold:
- state IDLE;
- rr_ptr = NUM_CORES-1, so core 0 has first priority;
- rdata_q, core_rdata, core_ready, ram_addr, ram_wdata, ram_we, ram_re all 0.
REQ-028 Reset asserted mid-transaction SHALL abort it immediately with no ready pulse; the aborted core re-arbitrates normally after release.

Structure
REQ-029 A shared package mem_arb_pkg SHALL hold:
- the memcontrol encodings (MC_IDLE, MC_READ, MC_WRITE);
- the FSM state encoding;
- the NUM_CORES default.
REQ-030 The round-robin selection (request vector, rr_ptr, mask -> grant index and valid) SHALL be a combinational sub-module rr_arbiter.

Verification
REQ-031 Single write then read:
- Stimulus: core 0 writes 0x00A5 to address 0x0010, then reads 0x0010.
- Response: ram_we for one cycle with addr 0x0010 and data 0x00A5; ready[0] after 2 edges; the read returns core_rdata=0x00A5 with ready[0] after 3 edges.
REQ-032 All-core contention:
- Stimulus: all 4 cores request in the same cycle after reset.
- Response: grants in order 0,1,2,3; each ready pulses once.
REQ-033 Held request:
- Stimulus: core 2 holds its read one cycle past ready while core 3 also requests.
- Response: core 3 is served next; core 2 is not double-served.
REQ-034 Reserved code:
- Stimulus: core 1 drives memcontrol=11 for 10 cycles.
- Response: no ram_we or ram_re; FSM stays in IDLE.
REQ-035 Reset in WAIT:
- Stimulus: Reset asserted during WAIT of a core 1 read.
- Response: no ready pulse; outputs 0; after release, core 1 (still requesting) completes the read.
